// File: rtl/gcd.sv
// -----------------------------------------------------------------------------
// gcd -- iterative greatest-common-divisor engine for unsigned integers.
//
// An operand pair is captured on any rising edge where enable is high, from
// any state. The engine then runs a subtract/swap Euclid loop, one step per
// clock. It presents the result on y together with a valid level. That level
// holds until the next accepted request. There is no back-pressure, and only
// one operation is in flight: a new request during CALC silently aborts the
// job in progress.
//
// Ports
//   clk     in   1           rising-edge clock
//   reset   in   1           asynchronous, active-low reset
//   enable  in   1           start strobe; a/b sampled on the edge where high
//   a       in   DATA_WIDTH  operand A, unsigned
//   b       in   DATA_WIDTH  operand B, unsigned
//   valid   out  1           result valid (level)
//   y       out  DATA_WIDTH  gcd(a,b); meaningful only while valid=1
// -----------------------------------------------------------------------------
module gcd #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] x, x_nx;      // working operand, kept >= z after a swap
  logic [DATA_WIDTH-1:0] z, z_nx;      // working operand; zero means x holds the gcd
  logic [DATA_WIDTH-1:0] y_nx;
  logic                  valid_nx;

  // One comparison is shared by the swap decision and the subtract guard. The
  // subtract only happens when x >= z, so it can never wrap.
  logic                  x_lt_z;
  logic [DATA_WIDTH-1:0] x_minus_z;

  assign x_lt_z    = (x < z);
  assign x_minus_z = x - z;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge; a blocking swap of x/z would corrupt one side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x     <= '0;
      z     <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      z     <= z_nx;
      y     <= y_nx;
      valid <= valid_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a hold default before any branch,
  // so no path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nx = state;
    x_nx     = x;
    z_nx     = z;
    y_nx     = y;
    valid_nx = valid;

    if (enable) begin
      // Acceptance wins in every state. Dropping valid on this same edge means
      // a host that polls after releasing enable never sees a stale result.
      x_nx     = a;
      z_nx     = b;
      valid_nx = 1'b0;
      state_nx = CALC;
    end else begin
      unique case (state)
        IDLE: ;  // wait for a request

        CALC: begin
          if (z == '0) begin
            y_nx     = x;
            valid_nx = 1'b1;
            state_nx = DONE;
          end else if (x_lt_z) begin
            x_nx = z;
            z_nx = x;
          end else begin
            x_nx = x_minus_z;
          end
        end

        DONE: ;  // y and valid hold until the next request

        default: begin
          // Unused encoding: recover to a quiet idle with no claimed result.
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd.sv
// -----------------------------------------------------------------------------
// tb_gcd -- directed self-checking bench for gcd at DATA_WIDTH=9.
// Inputs change on the falling edge and outputs are sampled there. Each
// expected value is hand-computed.
// -----------------------------------------------------------------------------
module tb_gcd;

  localparam int W      = 9;
  localparam int BUDGET = 2000;  // > worst case (511,1) of ~513 clocks

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;

  gcd #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .y      (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: strobe enable for exactly one rising edge.
  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
    enable = 1'b1;
    a      = av;
    b      = bv;
    @(negedge clk);
    enable = 1'b0;
    check("valid_low_after_accept", valid, 0);
  endtask

  // Wait a bounded number of cycles for valid, then check y.
  task automatic wait_result(input string tag, input logic [W-1:0] exp);
    int n = 0;
    while (!valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_no_timeout"}, (n < BUDGET), 1);
    check(tag, y, exp);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_y", y, 0);
    reset = 1'b1;
    @(negedge clk);

    // Load a nonzero y so the asynchronous reset check below is meaningful.
    start(9'd30, 9'd12);
    wait_result("gcd_30_12", 9'd6);

    // 1. Reset asserted mid-CALC clears everything without waiting for an edge.
    start(9'd511, 9'd1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_valid", valid, 0);
    check("async_reset_y", y, 0);
    @(negedge clk);
    check("reset_held_valid", valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", valid, 0);
    start(9'd9, 9'd27);
    wait_result("gcd_9_27", 9'd9);

    // 2. The result holds in DONE, and operand changes without enable are ignored.
    start(9'd49, 9'd21);
    wait_result("gcd_49_21", 9'd7);
    for (int i = 0; i < 10; i++) begin
      a = 9'(i * 37 + 3);
      b = 9'(i * 11 + 1);
      @(negedge clk);
      check("hold_valid", valid, 1);
      check("hold_y", y, 7);
    end

    // 3. Equal operands, then a back-to-back request from DONE.
    start(9'd40, 9'd40);
    wait_result("gcd_40_40", 9'd40);
    start(9'd250, 9'd190);
    wait_result("gcd_250_190", 9'd10);

    // 4. Divisor cases and zero operands.
    start(9'd250, 9'd5);
    wait_result("gcd_250_5", 9'd5);
    start(9'd0, 9'd17);
    wait_result("gcd_0_17", 9'd17);
    start(9'd17, 9'd0);
    wait_result("gcd_17_0", 9'd17);
    start(9'd0, 9'd0);
    wait_result("gcd_0_0", 9'd0);

    // 5. Worst-case latency.
    start(9'd511, 9'd1);
    wait_result("gcd_511_1", 9'd1);

    // 6. A restart mid-CALC aborts the first job and yields a single result.
    start(9'd256, 9'd2);
    repeat (3) @(negedge clk);
    check("restart_no_early_valid", valid, 0);
    start(9'd12, 9'd18);
    wait_result("gcd_restart_12_18", 9'd6);
    repeat (5) @(negedge clk);
    check("restart_hold_valid", valid, 1);
    check("restart_hold_y", y, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
